// File: rtl/ipc_doorbell_pkg.sv
// Shared constants for the HPS <-> Nios II doorbell controller:
// Avalon word offsets and STATUS register bit positions.
package ipc_doorbell_pkg;

    localparam logic [1:0] REG_TX     = 2'd0;
    localparam logic [1:0] REG_RX     = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_TXFULL = 16;
    localparam int ST_RXNE   = 17;
    localparam int ST_OVF    = 18;

endpackage

// File: rtl/ipc_doorbell_ctrl_fifo.sv
// ipc_sync_fifo: single-clock FIFO carrying notify IDs one way.
// Ports: push_i/pop_i/din_i in; dout_o (combinational head), count_o, full_o, empty_o out.
module ipc_sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  logic [DATA_W-1:0]             din_i,
    output logic [DATA_W-1:0]             dout_o,
    output logic [$clog2(DEPTH):0]        count_o,
    output logic                          full_o,
    output logic                          empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // A pop in the same cycle frees the slot, so a push to a full FIFO is kept.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/ipc_doorbell_ctrl.sv
// Doorbell controller: two Avalon-MM slaves (HPS side 0, Nios side 1), two ID FIFOs.
// Ports: clk_clk, reset_reset_n, h_*/n_* Avalon slaves (readdata latency 1), h_irq/n_irq levels.
module ipc_doorbell_ctrl
    import ipc_doorbell_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [1:0]  h_address,
    input  logic        h_write,
    input  logic [31:0] h_writedata,
    input  logic        h_read,
    output logic [31:0] h_readdata,
    input  logic [1:0]  n_address,
    input  logic        n_write,
    input  logic [31:0] n_writedata,
    input  logic        n_read,
    output logic [31:0] n_readdata,
    output logic        h_irq,
    output logic        n_irq
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Index 0 = HPS side / fifo_h2n, index 1 = Nios side / fifo_n2h.
    // Side s transmits into fifo[s] and receives from fifo[s^1].
    logic [1:0]        addr [2];
    logic [31:0]       wdata [2];
    logic [1:0]        wr, rd;

    logic [1:0]        push, pop, push_ok, full, empty;
    logic [DATA_W-1:0] dout [2];
    logic [CNT_W-1:0]  count [2];
    logic [CNT_W-1:0]  cnt_nxt [2];

    logic [1:0]        ovf_q, ovf_d;
    logic [1:0]        en_q, en_d;
    logic [1:0]        irq_q, irq_d;
    logic [31:0]       rdata_q [2];
    logic [31:0]       rdata_d [2];
    logic [31:0]       st;

    logic              unused_wdata;

    assign addr[0]  = h_address;
    assign addr[1]  = n_address;
    assign wdata[0] = h_writedata;
    assign wdata[1] = n_writedata;
    assign wr       = {n_write, h_write};
    assign rd       = {n_read, h_read};

    assign unused_wdata = ^{h_writedata, n_writedata};

    ipc_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_h2n (
        .clk_i   (clk_clk),
        .rst_ni  (reset_reset_n),
        .push_i  (push[0]),
        .pop_i   (pop[0]),
        .din_i   (h_writedata[DATA_W-1:0]),
        .dout_o  (dout[0]),
        .count_o (count[0]),
        .full_o  (full[0]),
        .empty_o (empty[0])
    );

    ipc_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_n2h (
        .clk_i   (clk_clk),
        .rst_ni  (reset_reset_n),
        .push_i  (push[1]),
        .pop_i   (pop[1]),
        .din_i   (n_writedata[DATA_W-1:0]),
        .dout_o  (dout[1]),
        .count_o (count[1]),
        .full_o  (full[1]),
        .empty_o (empty[1])
    );

    // FIFO-side strobes; a read paired with a write on the same side never pops.
    always_comb begin
        push    = '0;
        pop     = '0;
        push_ok = '0;
        for (int f = 0; f < 2; f++) begin
            push[f]    = wr[f] & (addr[f] == REG_TX);
            pop[f]     = rd[f^1] & ~wr[f^1] & (addr[f^1] == REG_RX) & ~empty[f];
            push_ok[f] = push[f] & (~full[f] | pop[f]);
            cnt_nxt[f] = count[f] + CNT_W'(push_ok[f]) - CNT_W'(pop[f]);
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        en_d  = en_q;
        irq_d = '0;
        st    = '0;
        for (int s = 0; s < 2; s++) begin
            rdata_d[s] = rdata_q[s];
            if (push[s] & ~push_ok[s])
                ovf_d[s] = 1'b1;
            else if (wr[s] && addr[s] == REG_STATUS && wdata[s][ST_OVF])
                ovf_d[s] = 1'b0;
            if (wr[s] && addr[s] == REG_CTRL)
                en_d[s] = wdata[s][0];

            st                = '0;
            st[CNT_W-1:0]     = count[s^1];
            st[ST_TXFULL]     = full[s];
            st[ST_RXNE]       = ~empty[s^1];
            st[ST_OVF]        = ovf_q[s];

            if (rd[s]) begin
                rdata_d[s] = '0;
                if (!wr[s]) begin
                    case (addr[s])
                        REG_RX:
                            if (!empty[s^1]) rdata_d[s] = 32'(dout[s^1]);
                        REG_STATUS: rdata_d[s] = st;
                        REG_CTRL:   rdata_d[s] = {31'd0, en_q[s]};
                        default:    rdata_d[s] = '0;
                    endcase
                end
            end
            // Level follows post-update state so it tracks push/pop edges exactly.
            irq_d[s] = en_d[s] & (cnt_nxt[s^1] != '0);
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ovf_q      <= '0;
            en_q       <= '0;
            irq_q      <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
        end else begin
            ovf_q      <= ovf_d;
            en_q       <= en_d;
            irq_q      <= irq_d;
            rdata_q[0] <= rdata_d[0];
            rdata_q[1] <= rdata_d[1];
        end
    end

    assign h_readdata = rdata_q[0];
    assign n_readdata = rdata_q[1];
    assign h_irq      = irq_q[0];
    assign n_irq      = irq_q[1];

endmodule

// File: tb/tb_ipc_doorbell_ctrl.sv
// Scoreboard bench for ipc_doorbell_ctrl: directed scenarios plus random traffic,
// expectations from a queue-based reference model of both doorbell directions.
module tb_ipc_doorbell_ctrl;
    import ipc_doorbell_pkg::*;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int NONE = 0, WR = 1, RD = 2, RW = 3;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [1:0]  h_address, n_address;
    logic        h_write, n_write, h_read, n_read;
    logic [31:0] h_writedata, n_writedata;
    logic [31:0] h_readdata, n_readdata;
    logic        h_irq, n_irq;

    ipc_doorbell_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .h_address     (h_address),
        .h_write       (h_write),
        .h_writedata   (h_writedata),
        .h_read        (h_read),
        .h_readdata    (h_readdata),
        .n_address     (n_address),
        .n_write       (n_write),
        .n_writedata   (n_writedata),
        .n_read        (n_read),
        .n_readdata    (n_readdata),
        .h_irq         (h_irq),
        .n_irq         (n_irq)
    );

    always #5 clk_clk = ~clk_clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: message queues per direction plus per-side flags.
    logic [DATA_W-1:0] h2n[$], n2h[$];
    logic [31:0]       rdq_h[$], rdq_n[$];
    bit                irqq_h[$], irqq_n[$];
    bit                ovf_m[2], en_m[2];

    function automatic int sz(int f);
        return (f == 0) ? h2n.size() : n2h.size();
    endfunction

    function automatic logic [DATA_W-1:0] head(int f);
        return (f == 0) ? h2n[0] : n2h[0];
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares readdata after every sampled read, irq every cycle.
    always @(posedge clk_clk) begin
        bit rh, rn, ei;
        logic [31:0] e;
        rh = h_read;
        rn = n_read;
        #1;
        if (reset_reset_n) begin
            if (rh && rdq_h.size() > 0) begin
                e = rdq_h.pop_front();
                check("h_readdata", h_readdata, e);
            end
            if (rn && rdq_n.size() > 0) begin
                e = rdq_n.pop_front();
                check("n_readdata", n_readdata, e);
            end
            if (irqq_h.size() > 0) begin
                ei = irqq_h.pop_front();
                check("h_irq", 32'(h_irq), 32'(ei));
            end
            if (irqq_n.size() > 0) begin
                ei = irqq_n.pop_front();
                check("n_irq", 32'(n_irq), 32'(ei));
            end
        end
    end

    // One bus cycle on both sides: drive pins, predict, wait for the next negedge.
    task automatic apply(input int hk, input logic [1:0] ha, input logic [31:0] hd,
                         input int nk, input logic [1:0] na, input logic [31:0] nd);
        int          k[2];
        logic [1:0]  a[2];
        logic [31:0] d[2];
        bit          pm[2];
        logic [31:0] e;
        k[0] = hk; a[0] = ha; d[0] = hd;
        k[1] = nk; a[1] = na; d[1] = nd;
        h_write = k[0][0]; h_read = k[0][1]; h_address = ha; h_writedata = hd;
        n_write = k[1][0]; n_read = k[1][1]; n_address = na; n_writedata = nd;
        for (int s = 0; s < 2; s++) begin
            pm[s] = 1'b0;
            if (k[s][1]) begin
                e = '0;
                if (!k[s][0]) begin
                    case (a[s])
                        REG_RX:
                            if (sz(s^1) > 0) begin
                                e = 32'(head(s^1));
                                pm[s] = 1'b1;
                            end
                        REG_STATUS:
                            e = {13'd0, ovf_m[s], sz(s^1) > 0,
                                 sz(s) == DEPTH, 16'(sz(s^1))};
                        REG_CTRL: e = {31'd0, en_m[s]};
                        default:  e = '0;
                    endcase
                end
                if (s == 0) rdq_h.push_back(e);
                else        rdq_n.push_back(e);
            end
        end
        for (int s = 0; s < 2; s++)
            if (pm[s]) begin
                if (s == 0) void'(n2h.pop_front());
                else        void'(h2n.pop_front());
            end
        for (int s = 0; s < 2; s++)
            if (k[s][0]) begin
                case (a[s])
                    REG_TX:
                        if (sz(s) < DEPTH) begin
                            if (s == 0) h2n.push_back(d[s][DATA_W-1:0]);
                            else        n2h.push_back(d[s][DATA_W-1:0]);
                        end else ovf_m[s] = 1'b1;
                    REG_STATUS: if (d[s][ST_OVF]) ovf_m[s] = 1'b0;
                    REG_CTRL:   en_m[s] = d[s][0];
                    default: ;
                endcase
            end
        irqq_h.push_back(en_m[0] && n2h.size() > 0);
        irqq_n.push_back(en_m[1] && h2n.size() > 0);
        @(negedge clk_clk);
    endtask

    task automatic idle();
        apply(NONE, 2'd0, 32'd0, NONE, 2'd0, 32'd0);
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock.
    task automatic do_reset();
        #2;
        reset_reset_n = 1'b0;
        h_write = 0; h_read = 0; n_write = 0; n_read = 0;
        #1;
        check("rst_h_readdata", h_readdata, 32'd0);
        check("rst_n_readdata", n_readdata, 32'd0);
        check("rst_h_irq", 32'(h_irq), 32'd0);
        check("rst_n_irq", 32'(n_irq), 32'd0);
        h2n.delete(); n2h.delete();
        rdq_h.delete(); rdq_n.delete();
        irqq_h.delete(); irqq_n.delete();
        ovf_m = '{0, 0};
        en_m  = '{0, 0};
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
    endtask

    task automatic rnd(output int k, output logic [1:0] a, output logic [31:0] d);
        int r;
        r = $urandom_range(0, 99);
        d = $urandom;
        a = 2'($urandom_range(0, 3));
        if (r < 20)      k = NONE;
        else if (r < 45) begin k = WR; a = REG_TX; end
        else if (r < 75) begin k = RD; a = REG_RX; end
        else if (r < 85) k = RD;
        else if (r < 95) begin k = WR; a = (r < 90) ? REG_CTRL : REG_STATUS; end
        else             k = RW;
    endtask

    initial begin
        int hk, nk, hs, ns;
        logic [1:0] ha, na;
        logic [31:0] hd, nd;

        reset_reset_n = 1'b1;
        h_address = 0; n_address = 0; h_writedata = 0; n_writedata = 0;
        h_write = 0; h_read = 0; n_write = 0; n_read = 0;
        @(negedge clk_clk);
        do_reset();

        // Reset state
        apply(RD, REG_STATUS, 0, RD, REG_STATUS, 0);

        // Basic notify
        apply(NONE, 0, 0, WR, REG_CTRL, 1);
        apply(WR, REG_TX, 32'h5, NONE, 0, 0);
        apply(NONE, 0, 0, RD, REG_STATUS, 0);
        apply(NONE, 0, 0, RD, REG_RX, 0);
        idle();

        // Full and overflow
        for (int i = 0; i < 9; i++) apply(WR, REG_TX, i, NONE, 0, 0);
        apply(RD, REG_STATUS, 0, NONE, 0, 0);
        for (int i = 0; i < 9; i++) apply(NONE, 0, 0, RD, REG_RX, 0);
        apply(WR, REG_STATUS, 32'h4_0000, NONE, 0, 0);
        apply(RD, REG_STATUS, 0, NONE, 0, 0);

        // Concurrent push/pop on full, then on empty
        for (int i = 0; i < 8; i++) apply(WR, REG_TX, 32'h100 + i, NONE, 0, 0);
        apply(WR, REG_TX, 32'h1AA, RD, REG_RX, 0);
        apply(RD, REG_STATUS, 0, RD, REG_STATUS, 0);
        for (int i = 0; i < 8; i++) apply(NONE, 0, 0, RD, REG_RX, 0);
        apply(WR, REG_TX, 32'h77, RD, REG_RX, 0);
        apply(NONE, 0, 0, RD, REG_STATUS, 0);
        apply(NONE, 0, 0, RD, REG_RX, 0);

        // Wrap, both directions interleaved
        apply(WR, REG_CTRL, 1, WR, REG_CTRL, 1);
        hs = 0; ns = 0;
        while (hs < 20 || ns < 20) begin
            hk = RD; ha = REG_RX; hd = 0;
            nk = RD; na = REG_RX; nd = 0;
            if (hs < 20 && $urandom_range(0, 2) != 0) begin
                hk = WR; ha = REG_TX; hd = 32'h200 + hs; hs++;
            end
            if (ns < 20 && $urandom_range(0, 2) != 0) begin
                nk = WR; na = REG_TX; nd = 32'h300 + ns; ns++;
            end
            apply(hk, ha, hd, nk, na, nd);
        end
        for (int i = 0; i < 9; i++) apply(RD, REG_RX, 0, RD, REG_RX, 0);

        // irq_en=0 keeps irq low with entries queued
        apply(WR, REG_CTRL, 0, WR, REG_CTRL, 0);
        apply(WR, REG_TX, 32'h11, WR, REG_TX, 32'h22);
        apply(RD, REG_STATUS, 0, RD, REG_STATUS, 0);
        apply(RD, REG_RX, 0, RD, REG_RX, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rnd(hk, ha, hd);
            rnd(nk, na, nd);
            apply(hk, ha, hd, nk, na, nd);
        end
        for (int i = 0; i < 9; i++) apply(RD, REG_RX, 0, RD, REG_RX, 0);

        // Reset mid-operation with 3 entries queued and readdata nonzero
        apply(WR, REG_CTRL, 1, WR, REG_CTRL, 1);
        for (int i = 0; i < 4; i++) apply(WR, REG_TX, 32'h40 + i, WR, REG_TX, 32'h50 + i);
        apply(RD, REG_RX, 0, RD, REG_RX, 0);
        do_reset();
        apply(RD, REG_STATUS, 0, RD, REG_STATUS, 0);
        apply(RD, REG_RX, 0, RD, REG_CTRL, 0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
